// File: rtl/alu_rx_deframer.sv
// Serial-input deframer for the 32-bit serial ALU: reassembles B/A operands from
// eight DATA bytes, checks count/CRC/opcode on the CTL byte, emits one pulse per packet.
module alu_rx_deframer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  op,
  output logic        out_valid,
  output logic        err_valid,
  output logic [2:0]  err_flags
);

  localparam int         OP_W          = 3;
  localparam logic [3:0] BYTES_PER_PKT = 4'd8;
  localparam logic [3:0] BYTE_CNT_MAX  = 4'd9;

  localparam logic [2:0] FLAG_DATA = 3'b100;
  localparam logic [2:0] FLAG_CRC  = 3'b010;
  localparam logic [2:0] FLAG_OP   = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TYPE,
    S_DATA,
    S_STOP,
    S_CHECK
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [2:0]      bit_cnt;
  logic            type_ctl;
  logic [7:0]      byte_sr;
  logic [63:0]     operand;
  logic [3:0]      byte_cnt;
  logic            frame_err;
  logic [6:0]      ctl_word;

  logic [OP_W-1:0] ctl_op;
  logic [3:0]      ctl_crc;
  logic [3:0]      crc_calc;
  logic            op_legal;
  logic            chk_good;
  logic [2:0]      chk_flags;

  // CRC4, x^4+x+1, init 0, MSB first, no reflection / final xor.
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'd0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  assign ctl_op   = ctl_word[6:4];
  assign ctl_crc  = ctl_word[3:0];
  assign crc_calc = crc4({operand, 1'b1, ctl_op});

  always_comb begin
    op_legal = 1'b0;
    case (ctl_op)
      3'b000, 3'b001, 3'b100, 3'b101: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
  end

  always_comb begin
    chk_good  = 1'b0;
    chk_flags = 3'b000;
    if ((byte_cnt != BYTES_PER_PKT) || frame_err) begin
      chk_flags = FLAG_DATA;
    end else if (ctl_crc != crc_calc) begin
      chk_flags = FLAG_CRC;
    end else if (!op_legal) begin
      chk_flags = FLAG_OP;
    end else begin
      chk_good = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!sin) state_nxt = S_TYPE;
      S_TYPE:  state_nxt = S_DATA;
      S_DATA:  if (bit_cnt == 3'd7) state_nxt = S_STOP;
      S_STOP:  state_nxt = (sin && type_ctl) ? S_CHECK : S_IDLE;
      // A start bit seen during CHECK begins the next byte immediately.
      S_CHECK: state_nxt = sin ? S_IDLE : S_TYPE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= 3'd0;
      type_ctl  <= 1'b0;
      byte_sr   <= 8'd0;
      operand   <= 64'd0;
      byte_cnt  <= 4'd0;
      frame_err <= 1'b0;
      ctl_word  <= 7'd0;
      a         <= 32'd0;
      b         <= 32'd0;
      op        <= 3'd0;
      out_valid <= 1'b0;
      err_valid <= 1'b0;
      err_flags <= 3'd0;
    end else begin
      out_valid <= 1'b0;
      err_valid <= 1'b0;
      err_flags <= 3'd0;
      case (state)
        S_TYPE: begin
          type_ctl <= sin;
          bit_cnt  <= 3'd0;
        end
        S_DATA: begin
          byte_sr <= {byte_sr[6:0], sin};
          bit_cnt <= bit_cnt + 3'd1;
        end
        S_STOP: begin
          if (!sin) begin
            frame_err <= 1'b1;
          end else if (type_ctl) begin
            ctl_word <= byte_sr[6:0];
          end else begin
            operand <= {operand[55:0], byte_sr};
            if (byte_cnt != BYTE_CNT_MAX) byte_cnt <= byte_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          byte_cnt  <= 4'd0;
          frame_err <= 1'b0;
          out_valid <= chk_good;
          err_valid <= !chk_good;
          err_flags <= chk_flags;
          if (chk_good) begin
            b  <= operand[63:32];
            a  <= operand[31:0];
            op <= ctl_op;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rx_deframer.sv
// Directed bench for alu_rx_deframer: table of packets plus hand-written corner sequences,
// with a pulse scoreboard that checks flags, held operands and pulse timing.
module tb_alu_rx_deframer;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        out_valid;
  logic        err_valid;
  logic [2:0]  err_flags;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_t0 = 0;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  typedef struct {
    logic [2:0]  flags;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    logic [3:0]  crc_xor;
    logic        gap;
    logic [2:0]  flags;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[10];
  logic [31:0] mdl_a;
  logic [31:0] mdl_b;
  logic [2:0]  mdl_op;

  alu_rx_deframer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .err_valid (err_valid),
    .err_flags (err_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference CRC by polynomial long division of {B, A, 1, OP} * x^4.
  function automatic logic [3:0] crc_ref(input logic [31:0] bb, input logic [31:0] aa,
                                         input logic [2:0] o);
    logic [71:0] r;
    r = {bb, aa, 1'b1, o, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && (out_valid || err_valid)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: out_valid=%0b err_valid=%0b err_flags=%b, required no pulse",
                 out_valid, err_valid, err_flags);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_exclusive", 64'(out_valid & err_valid), 64'd0);
        chk("out_valid", 64'(out_valid), 64'(e.flags == 3'b000));
        chk("err_valid", 64'(err_valid), 64'(e.flags != 3'b000));
        chk("err_flags", 64'(err_flags), 64'(e.flags));
        chk("a", 64'(a), 64'(e.a));
        chk("b", 64'(b), 64'(e.b));
        chk("op", 64'(op), 64'(e.op));
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic send_byte(input logic typ, input logic [7:0] d, input logic stop);
    logic [10:0] f;
    f = {1'b0, typ, d, stop};
    last_t0 = cyc + 1;
    for (int i = 10; i >= 0; i--) begin
      sin = f[i];
      @(negedge clk);
    end
  endtask

  task automatic send_data(input logic [63:0] d, input int first, input int last);
    for (int k = first; k <= last; k++) send_byte(1'b0, d[63-8*k -: 8], 1'b1);
  endtask

  task automatic expect_pulse(input logic [2:0] flags, input logic [31:0] a_v,
                              input logic [31:0] b_v, input logic [2:0] op_v);
    exp_t e;
    if (flags == 3'b000) begin
      mdl_a  = a_v;
      mdl_b  = b_v;
      mdl_op = op_v;
    end
    e.flags = flags;
    e.a     = mdl_a;
    e.b     = mdl_b;
    e.op    = mdl_op;
    e.cyc   = last_t0 + 11;
    exp_q.push_back(e);
  endtask

  task automatic send_pkt(input logic [31:0] b_v, input logic [31:0] a_v, input logic [2:0] op_v,
                          input logic [3:0] crc_v, input logic [2:0] flags);
    send_data({b_v, a_v}, 0, 7);
    send_byte(1'b1, {1'b0, op_v, crc_v}, 1'b1);
    expect_pulse(flags, a_v, b_v, op_v);
  endtask

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_a"}, 64'(a), 64'd0);
    chk({tag, "_b"}, 64'(b), 64'd0);
    chk({tag, "_op"}, 64'(op), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_err_valid"}, 64'(err_valid), 64'd0);
    chk({tag, "_err_flags"}, 64'(err_flags), 64'd0);
  endtask

  initial begin
    logic [63:0] d;
    logic [3:0]  crc;

    rst_n  = 1'b0;
    sin    = 1'b1;
    mdl_a  = 32'd0;
    mdl_b  = 32'd0;
    mdl_op = 3'd0;

    //           B             A             OP      crc^  gap   flags
    vecs[0] = '{32'h0000_0003, 32'h0000_0005, OP_ADD, 4'h0, 1'b1, 3'b000};
    vecs[1] = '{32'h0000_0003, 32'h0000_0005, OP_ADD, 4'h1, 1'b0, 3'b010};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, OP_AND, 4'h0, 1'b0, 3'b000};
    vecs[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 3'b111, 4'h0, 1'b1, 3'b001};
    vecs[4] = '{32'h1234_5678, 32'h9ABC_DEF0, OP_OR,  4'h0, 1'b0, 3'b000};
    vecs[5] = '{32'hDEAD_BEEF, 32'h0000_0001, OP_SUB, 4'h0, 1'b1, 3'b000};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 3'b010, 4'h0, 1'b1, 3'b001};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000, 3'b011, 4'h0, 1'b0, 3'b001};
    vecs[8] = '{32'h7FFF_FFFF, 32'h8000_0000, 3'b110, 4'h8, 1'b0, 3'b010};
    vecs[9] = '{32'hAAAA_5555, 32'h0F0F_0F0F, OP_ADD, 4'h0, 1'b1, 3'b000};

    #12;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 10; i++) begin
      crc = crc_ref(vecs[i].b, vecs[i].a, vecs[i].op) ^ vecs[i].crc_xor;
      send_pkt(vecs[i].b, vecs[i].a, vecs[i].op, crc, vecs[i].flags);
      if (vecs[i].gap) idle(3);
    end
    idle(3);

    // Seven DATA bytes, CRC as if A[7:0] were zero, then a good packet back-to-back.
    d = {32'h0000_0003, 32'h0000_0005};
    send_data(d, 0, 6);
    send_byte(1'b1, {1'b0, OP_ADD, crc_ref(32'h0000_0003, 32'h0000_0000, OP_ADD)}, 1'b1);
    expect_pulse(3'b100, 32'd0, 32'd0, 3'd0);
    send_pkt(32'hFFFF_FFFF, 32'h0000_0001, OP_AND, crc_ref(32'hFFFF_FFFF, 32'h1, OP_AND), 3'b000);
    idle(3);

    // CTL as the very first byte of a packet.
    send_byte(1'b1, {1'b0, OP_ADD, crc_ref(32'h0, 32'h0, OP_ADD)}, 1'b1);
    expect_pulse(3'b100, 32'd0, 32'd0, 3'd0);
    idle(2);

    // Framing error with byte count otherwise correct, then a good packet.
    d = {32'h1122_3344, 32'h5566_7788};
    send_data(d, 0, 2);
    send_byte(1'b0, d[39:32], 1'b0);
    send_data(d, 3, 7);
    send_byte(1'b1, {1'b0, OP_ADD, crc_ref(d[63:32], d[31:0], OP_ADD)}, 1'b1);
    expect_pulse(3'b100, 32'd0, 32'd0, 3'd0);
    send_pkt(32'hCAFE_F00D, 32'h0000_0007, OP_SUB, crc_ref(32'hCAFE_F00D, 32'h7, OP_SUB), 3'b000);
    idle(3);

    // Framing error on the fourth byte followed by seven more good bytes.
    send_data(d, 0, 2);
    send_byte(1'b0, d[39:32], 1'b0);
    send_data(d, 3, 7);
    send_data(d, 6, 7);
    send_byte(1'b1, {1'b0, OP_ADD, crc_ref(d[63:32], d[31:0], OP_ADD)}, 1'b1);
    expect_pulse(3'b100, 32'd0, 32'd0, 3'd0);
    send_pkt(32'h0000_0010, 32'h0000_0020, OP_OR, crc_ref(32'h10, 32'h20, OP_OR), 3'b000);
    idle(3);

    // 24 DATA bytes: the byte counter must saturate rather than wrap back to 8.
    send_data(d, 0, 7);
    send_data(d, 0, 7);
    send_data(d, 0, 7);
    send_byte(1'b1, {1'b0, OP_ADD, crc_ref(d[63:32], d[31:0], OP_ADD)}, 1'b1);
    expect_pulse(3'b100, 32'd0, 32'd0, 3'd0);
    idle(3);

    // Asynchronous reset in the middle of DATA byte 5.
    d = {32'h0BAD_0BAD, 32'h0000_0001};
    send_data(d, 0, 3);
    sin = 1'b0; @(negedge clk);
    sin = 1'b0; @(negedge clk);
    sin = 1'b1; @(negedge clk);
    sin = 1'b0; @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    mdl_a  = 32'd0;
    mdl_b  = 32'd0;
    mdl_op = 3'd0;
    @(negedge clk);
    @(negedge clk);
    sin   = 1'b1;
    rst_n = 1'b1;
    idle(2);
    send_pkt(32'hA5A5_A5A5, 32'h5A5A_5A5A, OP_OR, crc_ref(32'hA5A5_A5A5, 32'h5A5A_5A5A, OP_OR),
             3'b000);

    idle(20);
    chk("pending_pulses", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
